// File: rtl/gpio_led_pkg.sv
// Shared encodings, widths and LED constants for the GPIO LED sequencer.
`timescale 1ns/1ps
package gpio_led_pkg;

    localparam int MODE_W  = 2;
    localparam int SPEED_W = 2;
    localparam int CNT_W   = 32;

    typedef enum logic [MODE_W-1:0] {
        CHASE_UP   = 2'd0,
        CHASE_DOWN = 2'd1,
        BOUNCE     = 2'd2,
        BLINK      = 2'd3
    } mode_t;

    localparam logic [7:0] LED_ALL_ON  = 8'hFF;
    localparam logic [7:0] LED_ALL_OFF = 8'h00;

    function automatic logic [7:0] led_onehot(input logic [2:0] p);
        return 8'b0000_0001 << p;
    endfunction

endpackage

// File: rtl/gpio_led_sequencer_tick.sv
// Step prescaler: pulses tick once every CLK_DIV << speed cycles.
// clr restarts the period; hold freezes the count and masks tick.
`timescale 1ns/1ps
module led_tick_gen
    import gpio_led_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               hold,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick
);

    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   period;
    logic [CNT_W-1:0] last;

    // One extra bit so CLK_DIV = 2^29 at the slowest speed does not overflow.
    assign period = (CNT_W + 1)'(CLK_DIV) << speed;
    assign last   = CNT_W'(period - 1'b1);
    assign tick   = !hold && (count == last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (!hold) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_led_sequencer.sv
// Button-driven LED sequencer: four display modes, four step speeds, pause.
// Button events act two edges after the level rises; LED decode is combinational.
`timescale 1ns/1ps
module gpio_led_sequencer
    import gpio_led_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_speed,
    input  logic              btn_pause,
    output logic [7:0]        GPIO_LED,
    output logic [MODE_W-1:0] mode,
    output logic              paused
);

    logic [2:0]         btn_meta, btn_sync, btn_prev, btn_evt;
    logic               mode_evt, speed_evt, pause_evt, tick;
    mode_t              mode_q, mode_next;
    logic [2:0]         pos;
    logic               dir, phase;
    logic [SPEED_W-1:0] speed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
            btn_prev <= '0;
        end else begin
            btn_meta <= {btn_pause, btn_speed, btn_mode};
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    assign btn_evt   = btn_sync & ~btn_prev;
    assign mode_evt  = btn_evt[0];
    assign speed_evt = btn_evt[1];
    assign pause_evt = btn_evt[2];
    assign mode_next = mode_t'(mode_q + 2'd1);

    led_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (mode_evt | speed_evt),
        .hold  (paused),
        .speed (speed),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= CHASE_UP;
            pos    <= '0;
            dir    <= 1'b0;
            phase  <= 1'b0;
            speed  <= '0;
            paused <= 1'b0;
        end else begin
            // A mode or speed change restarts the period, so it also swallows a pending step.
            if (mode_evt) begin
                mode_q <= mode_next;
                case (mode_next)
                    CHASE_UP:   pos <= 3'd0;
                    CHASE_DOWN: pos <= 3'd7;
                    BOUNCE: begin
                        pos <= 3'd0;
                        dir <= 1'b0;
                    end
                    BLINK:      phase <= 1'b1;
                endcase
            end else if (tick && !speed_evt) begin
                case (mode_q)
                    CHASE_UP:   pos <= pos + 3'd1;
                    CHASE_DOWN: pos <= pos - 3'd1;
                    BOUNCE: begin
                        if (!dir) begin
                            if (pos == 3'd7) begin
                                dir <= 1'b1;
                                pos <= 3'd6;
                            end else begin
                                pos <= pos + 3'd1;
                            end
                        end else begin
                            if (pos == 3'd0) begin
                                dir <= 1'b0;
                                pos <= 3'd1;
                            end else begin
                                pos <= pos - 3'd1;
                            end
                        end
                    end
                    BLINK:      phase <= ~phase;
                endcase
            end
            if (speed_evt) speed  <= speed + 2'd1;
            if (pause_evt) paused <= ~paused;
        end
    end

    assign mode     = mode_q;
    assign GPIO_LED = (mode_q == BLINK) ? (phase ? LED_ALL_ON : LED_ALL_OFF)
                                        : led_onehot(pos);

endmodule

// File: tb/tb_gpio_led_sequencer.sv
// Directed bench for gpio_led_sequencer with CLK_DIV = 4: vector table plus reset corner case.
`timescale 1ns/1ps
module tb_gpio_led_sequencer;

    typedef struct {
        logic       bm;
        logic       bs;
        logic       bp;
        int         wait_n;
        logic [7:0] led;
        logic [1:0] mode;
        logic       paused;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_speed = 1'b0;
    logic       btn_pause = 1'b0;
    logic [7:0] gpio_led;
    logic [1:0] mode;
    logic       paused;

    int total = 0;
    int bad = 0;
    vec_t vecs[$];

    gpio_led_sequencer #(.CLK_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_speed (btn_speed),
        .btn_pause (btn_pause),
        .GPIO_LED  (gpio_led),
        .mode      (mode),
        .paused    (paused)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic bm, input logic bs, input logic bp, input int w,
                                input logic [7:0] led, input logic [1:0] m, input logic p);
        vec_t v;
        v.bm = bm; v.bs = bs; v.bp = bp; v.wait_n = w;
        v.led = led; v.mode = m; v.paused = p;
        vecs.push_back(v);
    endfunction

    initial begin
        // Chase up, 4-edge period, from reset release.
        add(0,0,0, 0, 8'h01, 0, 0);
        add(0,0,0, 3, 8'h01, 0, 0);
        add(0,0,0, 1, 8'h02, 0, 0);
        add(0,0,0, 4, 8'h04, 0, 0);
        add(0,0,0, 4, 8'h08, 0, 0);
        add(0,0,0, 4, 8'h10, 0, 0);
        add(0,0,0, 4, 8'h20, 0, 0);
        add(0,0,0, 4, 8'h40, 0, 0);
        add(0,0,0, 4, 8'h80, 0, 0);
        add(0,0,0, 4, 8'h01, 0, 0);
        // Mode press held for 23 edges: one change to CHASE_DOWN.
        add(1,0,0, 2, 8'h01, 0, 0);
        add(1,0,0, 1, 8'h80, 1, 0);
        add(1,0,0, 4, 8'h40, 1, 0);
        add(1,0,0, 4, 8'h20, 1, 0);
        add(1,0,0, 12, 8'h04, 1, 0);
        // Into BOUNCE, then 16 steps.
        add(0,0,0, 2, 8'h04, 1, 0);
        add(1,0,0, 2, 8'h02, 1, 0);
        add(1,0,0, 1, 8'h01, 2, 0);
        add(0,0,0, 4, 8'h02, 2, 0);
        add(0,0,0, 4, 8'h04, 2, 0);
        add(0,0,0, 4, 8'h08, 2, 0);
        add(0,0,0, 4, 8'h10, 2, 0);
        add(0,0,0, 4, 8'h20, 2, 0);
        add(0,0,0, 4, 8'h40, 2, 0);
        add(0,0,0, 4, 8'h80, 2, 0);
        add(0,0,0, 4, 8'h40, 2, 0);
        add(0,0,0, 4, 8'h20, 2, 0);
        add(0,0,0, 4, 8'h10, 2, 0);
        add(0,0,0, 4, 8'h08, 2, 0);
        add(0,0,0, 4, 8'h04, 2, 0);
        add(0,0,0, 4, 8'h02, 2, 0);
        add(0,0,0, 4, 8'h01, 2, 0);
        add(0,0,0, 4, 8'h02, 2, 0);
        add(0,0,0, 4, 8'h04, 2, 0);
        // Speed presses: period 16, then wrap back to 4.
        add(0,1,0, 3, 8'h04, 2, 0);
        add(0,0,0, 2, 8'h04, 2, 0);
        add(0,1,0, 3, 8'h04, 2, 0);
        add(0,0,0, 15, 8'h04, 2, 0);
        add(0,0,0, 1, 8'h08, 2, 0);
        add(0,0,0, 16, 8'h10, 2, 0);
        add(0,1,0, 3, 8'h10, 2, 0);
        add(0,0,0, 2, 8'h10, 2, 0);
        add(0,1,0, 3, 8'h10, 2, 0);
        add(0,0,0, 3, 8'h10, 2, 0);
        add(0,0,0, 1, 8'h20, 2, 0);
        add(0,0,0, 3, 8'h20, 2, 0);
        // Pause at count 2, frozen 50 cycles, resume 2 edges before the step.
        add(0,0,1, 3, 8'h40, 2, 1);
        add(0,0,0, 50, 8'h40, 2, 1);
        add(0,0,1, 3, 8'h40, 2, 0);
        add(0,0,0, 1, 8'h40, 2, 0);
        add(0,0,0, 1, 8'h80, 2, 0);
        // Mode event on the tick cycle: BLINK entry with no step.
        add(0,0,0, 1, 8'h80, 2, 0);
        add(1,0,0, 2, 8'h80, 2, 0);
        add(1,0,0, 1, 8'hFF, 3, 0);
        add(0,0,0, 3, 8'hFF, 3, 0);
        add(0,0,0, 1, 8'h00, 3, 0);
        add(0,0,0, 4, 8'hFF, 3, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_led", gpio_led, 8'h01);
        chk("reset_mode", {6'd0, mode}, 8'd0);
        chk("reset_paused", {7'd0, paused}, 8'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            btn_mode  = vecs[i].bm;
            btn_speed = vecs[i].bs;
            btn_pause = vecs[i].bp;
            repeat (vecs[i].wait_n) @(posedge clk);
            #1;
            chk($sformatf("row%0d_led", i), gpio_led, vecs[i].led);
            chk($sformatf("row%0d_mode", i), {6'd0, mode}, {6'd0, vecs[i].mode});
            chk($sformatf("row%0d_paused", i), {7'd0, paused}, {7'd0, vecs[i].paused});
        end

        // Asynchronous reset mid-cycle while in BLINK with phase 1.
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_led", gpio_led, 8'h01);
        chk("async_reset_mode", {6'd0, mode}, 8'd0);
        chk("async_reset_paused", {7'd0, paused}, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_hold", gpio_led, 8'h01);
        @(posedge clk);
        #1;
        chk("post_reset_step", gpio_led, 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
